// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// The timeout counter width is derived here so the top and the counter agree.
package wb_initiator_pkg;

    localparam int DEFAULT_ADDR_W         = 32;
    localparam int DEFAULT_DATA_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1
    function automatic int tcnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEFAULT_TCNT_W = tcnt_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle timeout counter for wb_initiator.
// Only instantiated when WB_INITIATOR_TIMEOUT_EN is defined.
// expired_o is decoded from the count register, so it carries no input path.
module wb_timeout_cnt
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = tcnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count waiting cycles; clear has priority so each command starts from zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired_o = (r_cnt == LAST_CNT);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator.
// Turns a valid/ready command into one CYC/STB cycle and returns read data
// (or a timeout error) on a valid/ready response stream.
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN enables the bus timeout;
// without it BUS waits for ACK indefinitely and rsp_err_o is tied to 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cmd_ready_o high, waiting for a command
// BUS   | CYC/STB high with the registered command, waiting for ACK
// RSP   | rsp_valid_o high, holding data/error until rsp_ready_i
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    localparam int SEL_W = DATA_W / 8;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                w_accept;

    assign w_accept = (r_state == IDLE) && cmd_valid_i;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic w_cnt_en;
    logic w_expired;
    logic r_rsp_err;

    assign w_cnt_en = (r_state == BUS) && !wbm_ack_i;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .clear_i   (w_accept),
        .enable_i  (w_cnt_en),
        .expired_o (w_expired)
    );

    assign rsp_err_o = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign rsp_err_o        = 1'b0;
`endif

    // Command/response FSM; the command is latched once and held on the bus
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            r_rsp_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_sel   <= cmd_sel_i;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // ACK wins over an expiry in the same cycle
                    if (wbm_ack_i) begin
                        r_rsp_dat <= r_we ? '0 : wbm_dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        r_rsp_err <= 1'b0;
`endif
                        r_state   <= RSP;
                    end
`ifdef WB_INITIATOR_TIMEOUT_EN
                    else if (w_expired) begin
                        r_rsp_dat <= '0;
                        r_rsp_err <= 1'b1;
                        r_state   <= RSP;
                    end
`endif
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == RSP);
    assign rsp_dat_o   = r_rsp_dat;

    assign wbm_cyc_o   = (r_state == BUS);
    assign wbm_stb_o   = (r_state == BUS);
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: randomized commands, a delay-programmable
// slave, and a monitor comparing bus activity and responses against a
// transaction-level model.
module tb_wb_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int MAX_DLY = 11;
`else
    localparam bit TO_EN = 1'b0;
    localparam int MAX_DLY = 6;
`endif

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] rsp_dat;
        bit          err;
        int          k;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   stray_ack = 1'b0;
    int   bp_hold = 0;

    wb_initiator #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired t=%0t", name, $time);
    endtask

    // Transaction-level model: ACK is sampled d+1 cycles after acceptance,
    // expiry lands TO cycles after acceptance, ACK wins a tie.
    function automatic exp_t model(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                   input logic [3:0] sel, input int dly, input logic [31:0] rdata);
        exp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.dly = dly; e.rdata = rdata;
        e.err     = TO_EN && (dly + 1 > TO);
        e.rsp_dat = (we || e.err) ? 32'h0 : rdata;
        e.k       = e.err ? TO : dly + 1;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance
    task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int dly, input logic [31:0] rdata);
        int n;
        q.push_back(model(we, adr, dat, sel, dly, rdata));
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            bound_fail("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) bound_fail("drain");
    endtask

    // Slave: ACK for one cycle when the in-flight command's delay has elapsed
    initial begin
        int cnt;
        bit a;
        cnt = 0;
        wbm_ack = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wbm_cyc) cnt++;
            else cnt = 0;
            a = wbm_cyc && (q.size() > 0) && (cnt == q[0].dly + 1);
            wbm_ack = a || stray_ack;
            wbm_dat_i = (a && q.size() > 0) ? q[0].rdata : $urandom;
        end
    end

    // Response consumer
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_hold > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) bp_hold--;
            end else if (rand_rdy) begin
                rsp_ready = ($urandom_range(0, 1) == 1);
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        int  cyc_run;
        bit  prev_rv;
        cyc_run = 0;
        prev_rv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                cyc_run = 0;
                prev_rv = 1'b0;
            end else begin
                chk("cyc_eq_stb", wbm_stb, wbm_cyc);
                if (wbm_cyc) begin
                    cyc_run++;
                    if (q.size() == 0) begin
                        bound_fail("unexpected_cyc");
                    end else begin
                        chk("bus_we",  wbm_we,    q[0].we);
                        chk("bus_adr", wbm_adr,   q[0].adr);
                        chk("bus_dat", wbm_dat_o, q[0].dat);
                        chk("bus_sel", wbm_sel,   q[0].sel);
                        chk("bus_ready_low", cmd_ready, 1'b0);
                    end
                end
                if (rsp_valid && !prev_rv) begin
                    if (q.size() == 0) begin
                        bound_fail("unexpected_rsp");
                    end else begin
                        cur = q.pop_front();
                        chk("rsp_latency", cyc_run, cur.k);
                    end
                    cyc_run = 0;
                end
                if (rsp_valid) begin
                    chk("rsp_dat", rsp_dat, cur.rsp_dat);
                    chk("rsp_err", rsp_err, cur.err);
                    chk("rsp_ready_low", cmd_ready, 1'b0);
                    chk("rsp_cyc_low", wbm_cyc, 1'b0);
                end
                if (!wbm_cyc && !rsp_valid) chk("idle_ready", cmd_ready, 1'b1);
                prev_rv = rsp_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        #22;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_rsp_dat",   rsp_dat,   '0);
        chk("rst_cyc",       wbm_cyc,   1'b0);
        chk("rst_stb",       wbm_stb,   1'b0);
        chk("rst_we",        wbm_we,    1'b0);
        chk("rst_adr",       wbm_adr,   '0);
        chk("rst_dat",       wbm_dat_o, '0);
        chk("rst_sel",       wbm_sel,   '0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed write and read
        issue(1'b1, 32'h3000_0000, 32'h0000_1234, 4'hF, 1, 32'hCAFE_0001);
        drain();
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'h0000_00AB);
        drain();

        // Response backpressure with a second command waiting
        bp_hold = 5;
        issue(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'h1111_2222);
        issue(1'b1, 32'h3000_000C, 32'h5555_AAAA, 4'hC, 2, 32'h0);
        drain();

`ifdef WB_INITIATOR_TIMEOUT_EN
        // No ACK: timeout, then a stray ACK is ignored
        bp_hold = 3;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, 50, 32'h7777_7777);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) bound_fail("timeout_rsp");
        stray_ack = 1'b1;
        repeat (8) @(negedge clk);
        stray_ack = 1'b0;
        drain();
        // ACK on the expiry cycle wins; one cycle later is a timeout
        issue(1'b0, 32'h3000_0014, 32'h0, 4'hF, TO - 1, 32'h5A5A_5A5A);
        drain();
        issue(1'b0, 32'h3000_0018, 32'h0, 4'hF, TO, 32'hA5A5_A5A5);
        drain();
`endif

        // Randomized traffic
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, MAX_DLY), $urandom);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of BUS
        mon_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_cyc", wbm_cyc, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", wbm_cyc, 1'b0);
        chk("async_rst_stb", wbm_stb, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_cyc", wbm_cyc, 1'b0);
        @(negedge clk);
        mon_en = 1'b1;
        issue(1'b1, 32'h3000_0024, 32'hBEEF_0000, 4'h1, 2, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone classic initiator that drives the user-area Wishbone slave port. It converts a valid/ready command stream (address, data, byte selects, read/write) into one CYC/STB bus cycle and returns the read data or an error on a valid/ready response stream. It is the stimulus and bring-up master for user-project slaves such as the counter peripheral. It is also embedded as a local bus master in future user projects.

## Interface
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width; must be a multiple of 8
- TIMEOUT_CYCLES, 255, maximum cycles in BUS without ACK before abort; range 2..65535 (`WB_INITIATOR_TIMEOUT_EN` only)

Ports:
- wb_clk_i  in  1  the block's only clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready at rising edge
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  ADDR_W  byte address
- cmd_dat_i  in  DATA_W  write data
- cmd_sel_i  in  DATA_W/8  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready at rising edge
- rsp_dat_o  out  DATA_W  read data; 0 for writes and errors
- rsp_err_o  out  1  1 = timed out
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle/strobe; always equal
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_sel_o  out  DATA_W/8  byte selects
- wbm_dat_i  in  DATA_W  read data from slave
- wbm_ack_i  in  1  slave acknowledge

## Operation
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, register we/adr/dat/sel, clear the timeout counter and go to BUS.
- BUS:
  - wbm_cyc_o=wbm_stb_o=1; wbm_* hold the registered command unchanged.
  - On wbm_ack_i, capture rsp_dat=(we ? 0 : wbm_dat_i), set rsp_err=0 and go to RSP.
- RSP:
  - rsp_valid_o=1; rsp_dat_o/rsp_err_o stable.
  - On rsp_ready_i, go to IDLE.
- cmd_ready_o is 1 only in IDLE. rsp_valid_o is 1 only in RSP. No command is accepted while a response is pending.
- wbm_ack_i is ignored outside BUS.
- Timeout:
  - The counter increments each BUS cycle without ACK.
  - When the counter equals TIMEOUT_CYCLES-1 and ACK is absent, go to RSP with rsp_err=1 and rsp_dat=0.
  - If ACK and expiry fall in the same cycle, ACK wins and rsp_err=0.
- Reset values:
  - state=IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0.
  - wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_adr_o, wbm_dat_o and wbm_sel_o=0.
  - Timeout counter=0.
- Reset mid-transaction: CYC/STB drop asynchronously and the pending command and response are discarded.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- Command accepted at edge N: CYC/STB are high from N until the ACK edge N+k (k≥1).
- rsp_valid_o is high from N+k.
- cmd_ready_o returns high on the edge where the response handshakes.
- Best-case throughput is one transaction per 3 cycles (accept, ACK, response handshake).
- With a slave that ACKs one cycle after STB, a read takes 2 bus cycles and the response appears 2 cycles after acceptance.
- With timeout: rsp_err_o is asserted exactly TIMEOUT_CYCLES cycles after CYC rises; CYC is low the following cycle.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN` defined: timeout counter present; rsp_err_o behaves as specified; TIMEOUT_CYCLES is honoured.
- Not defined:
  - No counter; BUS waits for ACK indefinitely.
  - rsp_err_o is tied to 0; TIMEOUT_CYCLES is unused.

## Structure
- Shared package wb_initiator_pkg:
  - state enum {IDLE, BUS, RSP};
  - default width constants;
  - the $clog2-derived timeout counter width.
- One sub-module, wb_timeout_cnt:
  - inputs: clear, enable; output: expired;
  - generated only under `WB_INITIATOR_TIMEOUT_EN`.
- Everything else is inline in wb_initiator.

## Test plan
- Write: cmd adr=0x3000_0000, dat=0x0000_1234, sel=0xF, we=1; slave ACKs 1 cycle after STB.
  - Bus shows we=1 and the same adr/dat/sel for 2 cycles.
  - rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
- Read: slave returns 0x0000_00AB on a 3-cycle ACK delay → rsp_dat_o=0x0000_00AB; CYC is high for exactly 4 cycles.
- Response backpressure: rsp_ready_i low for 5 cycles.
  - rsp_valid_o and the data stay stable and cmd_ready_o stays 0.
  - A second cmd_valid_i is not accepted until the handshake.
- Timeout: TIMEOUT_CYCLES=8, slave never ACKs.
  - rsp_err_o=1 and rsp_dat_o=0, 8 cycles after CYC rises.
  - An ACK arriving later is ignored.
- ACK on the expiry cycle → rsp_err_o=0 and the read data is returned.
- Reset mid-BUS: drive wb_rst_ni low between edges → CYC/STB fall immediately; after release, state is IDLE, cmd_ready_o=1, rsp_valid_o=0.
